// File: rtl/uart_spi_cmd_parser.sv
// rtl/uart_spi_cmd_parser.sv - ASCII {op:addr:data} frame parser producing SPI command requests
module uart_spi_cmd_parser #(
  parameter int ADDR_DIGITS = 3,
  parameter int DATA_DIGITS = 5,
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int LEN_W       = 3,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                     i_clk_sys,
  input  logic                     i_rst,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  output logic                     o_rx_ready,
  output logic                     o_cmd_valid,
  input  logic                     i_cmd_ready,
  output logic                     o_cmd_wr,
  output logic [CH_W-1:0]          o_cmd_ch,
  output logic [4*ADDR_DIGITS-1:0] o_cmd_addr,
  output logic [4*DATA_DIGITS-1:0] o_cmd_data,
  output logic [LEN_W-1:0]         o_cmd_len,
  output logic                     o_err,
  output logic [2:0]               o_err_code
);

  localparam int AW   = 4 * ADDR_DIGITS;
  localparam int DW   = 4 * DATA_DIGITS;
  localparam int AC_W = $clog2(ADDR_DIGITS + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AC_W-1:0]  ADDR_MAX = AC_W'(ADDR_DIGITS);
  localparam logic [LEN_W-1:0] DATA_MAX = LEN_W'(DATA_DIGITS);
  localparam logic [TW-1:0]    TMO_MAX  = TW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {S_IDLE, S_OP, S_SEP, S_ADDR, S_DATA, S_ISSUE} state_t;

  state_t           state, nxt_state;
  logic             take, in_frame, err_evt;
  logic [2:0]       err_nxt;
  logic             is_hex, is_lower, is_upper;
  logic [3:0]       nib;
  logic [7:0]       letter_idx;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    data_q;
  logic [LEN_W-1:0] len_q;
  logic [AC_W-1:0]  addr_cnt;
  logic             wr_q;
  logic [CH_W-1:0]  ch_q;
  logic [TW-1:0]    tmo_cnt;

  assign take     = i_rx_valid && o_rx_ready;
  assign in_frame = (state == S_OP) || (state == S_SEP) || (state == S_ADDR) || (state == S_DATA);

  // Classify the incoming byte: hex nibble value and op letter index
  always_comb begin
    is_hex = 1'b1;
    nib    = 4'd0;
    if (i_rx_data >= "0" && i_rx_data <= "9")      nib = 4'(i_rx_data - 8'd48);
    else if (i_rx_data >= "a" && i_rx_data <= "f") nib = 4'(i_rx_data - 8'd87);
    else if (i_rx_data >= "A" && i_rx_data <= "F") nib = 4'(i_rx_data - 8'd55);
    else                                           is_hex = 1'b0;
    is_lower   = (i_rx_data >= "a") && (i_rx_data <= "z");
    is_upper   = (i_rx_data >= "A") && (i_rx_data <= "Z");
    letter_idx = is_lower ? (i_rx_data - 8'd97) : (i_rx_data - 8'd65);
  end

  // State register
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) state <= S_IDLE;
    else       state <= nxt_state;
  end

  // Next-state and error detection; any error drops back to IDLE
  always_comb begin
    nxt_state = state;
    err_evt   = 1'b0;
    err_nxt   = 3'd0;
    if (state == S_ISSUE) begin
      if (i_cmd_ready) nxt_state = S_IDLE;
    end else if (take) begin
      if (i_rx_data == "{") begin
        nxt_state = S_OP;
      end else begin
        case (state)
          S_OP: begin
            if (is_lower || is_upper) begin
              if (letter_idx >= 8'(N_CH)) begin err_evt = 1'b1; err_nxt = 3'd2; end
              else nxt_state = S_SEP;
            end else begin
              err_evt = 1'b1; err_nxt = 3'd1;
            end
          end
          S_SEP: begin
            if (i_rx_data == ":") nxt_state = S_ADDR;
            else begin err_evt = 1'b1; err_nxt = 3'd1; end
          end
          S_ADDR: begin
            if (is_hex) begin
              if (addr_cnt == ADDR_MAX) begin err_evt = 1'b1; err_nxt = 3'd3; end
            end else if (i_rx_data == ":") begin
              if (addr_cnt == '0) begin err_evt = 1'b1; err_nxt = 3'd4; end
              else nxt_state = S_DATA;
            end else begin
              err_evt = 1'b1; err_nxt = 3'd1;
            end
          end
          S_DATA: begin
            if (is_hex) begin
              if (len_q == DATA_MAX) begin err_evt = 1'b1; err_nxt = 3'd3; end
            end else if (i_rx_data == "}") begin
              nxt_state = S_ISSUE;
            end else begin
              err_evt = 1'b1; err_nxt = 3'd1;
            end
          end
          default: ;
        endcase
      end
    end else if (in_frame && tmo_cnt == TMO_MAX) begin
      err_evt = 1'b1;
      err_nxt = 3'd5;
    end
    if (err_evt) nxt_state = S_IDLE;
  end

  // Handshake outputs depend only on state
  always_comb begin
    o_rx_ready  = (state != S_ISSUE);
    o_cmd_valid = (state == S_ISSUE);
  end

  // Command fields: cleared on '{', shifted in as digits arrive, frozen in ISSUE
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      wr_q <= 1'b0; ch_q <= '0; addr_q <= '0; data_q <= '0; len_q <= '0; addr_cnt <= '0;
    end else if (take) begin
      if (i_rx_data == "{") begin
        wr_q <= 1'b0; ch_q <= '0; addr_q <= '0; data_q <= '0; len_q <= '0; addr_cnt <= '0;
      end else begin
        case (state)
          S_OP: if (is_lower || is_upper) begin
            wr_q <= is_lower;
            ch_q <= letter_idx[CH_W-1:0];
          end
          S_ADDR: if (is_hex && addr_cnt != ADDR_MAX) begin
            addr_q   <= (addr_q << 4) | AW'(nib);
            addr_cnt <= addr_cnt + 1'b1;
          end
          S_DATA: if (is_hex && len_q != DATA_MAX) begin
            data_q <= (data_q << 4) | DW'(nib);
            len_q  <= len_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Inter-byte timeout counter, only running while inside a frame
  always_ff @(posedge i_clk_sys) begin
    if (i_rst || take || !in_frame || err_evt) tmo_cnt <= '0;
    else                                        tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Error pulse the cycle after the offending byte; code held until the next error
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      o_err      <= 1'b0;
      o_err_code <= 3'd0;
    end else begin
      o_err <= err_evt;
      if (err_evt) o_err_code <= err_nxt;
    end
  end

  assign o_cmd_wr   = wr_q;
  assign o_cmd_ch   = ch_q;
  assign o_cmd_addr = addr_q;
  assign o_cmd_data = data_q;
  assign o_cmd_len  = len_q;

endmodule

// File: tb/tb_uart_spi_cmd_parser.sv
// tb/tb_uart_spi_cmd_parser.sv - directed self-checking bench for uart_spi_cmd_parser
module tb_uart_spi_cmd_parser;
  localparam int T = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        cmd_wr;
  logic [1:0]  cmd_ch;
  logic [11:0] cmd_addr;
  logic [19:0] cmd_data;
  logic [2:0]  cmd_len;
  logic        err;
  logic [2:0]  err_code;

  int passed = 0;
  int total  = 0;

  int          err_cnt = 0;
  int          cmd_cnt = 0;
  logic        rec_wr;
  logic [1:0]  rec_ch;
  logic [11:0] rec_addr;
  logic [19:0] rec_data;
  logic [2:0]  rec_len;
  logic [2:0]  rec_code;

  uart_spi_cmd_parser #(.TIMEOUT_CYC(T)) dut (
    .i_clk_sys(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready), .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
    .o_cmd_wr(cmd_wr), .o_cmd_ch(cmd_ch), .o_cmd_addr(cmd_addr), .o_cmd_data(cmd_data),
    .o_cmd_len(cmd_len), .o_err(err), .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  // Record every error pulse and every command handshake
  always @(negedge clk) begin
    #1;
    if (err === 1'b1) begin
      err_cnt++;
      rec_code = err_code;
    end
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      cmd_cnt++;
      rec_wr = cmd_wr; rec_ch = cmd_ch; rec_addr = cmd_addr; rec_data = cmd_data; rec_len = cmd_len;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      total++;
      $display("FAIL send_timeout: rx_ready stuck at %b, required 1", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic chk_cmd(input string nm, input logic wr, input logic [1:0] ch,
                         input logic [11:0] a, input logic [19:0] d, input logic [2:0] l);
    total++;
    if ({rec_wr, rec_ch, rec_addr, rec_data, rec_len} !== {wr, ch, a, d, l})
      $display("FAIL %s: got wr=%b ch=%0d addr=%h data=%h len=%0d, required wr=%b ch=%0d addr=%h data=%h len=%0d",
               nm, rec_wr, rec_ch, rec_addr, rec_data, rec_len, wr, ch, a, d, l);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    #1;
    total++;
    if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b, required 1", rx_ready); else passed++;
    total++;
    if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b, required 0", cmd_valid); else passed++;
    total++;
    if (err !== 1'b0 || err_code !== 3'd0) $display("FAIL reset_err: got %b/%0d, required 0/0", err, err_code); else passed++;
    total++;
    if ({cmd_wr, cmd_ch, cmd_addr, cmd_data, cmd_len} !== '0)
      $display("FAIL reset_cmd_fields: got %h, required 0", {cmd_wr, cmd_ch, cmd_addr, cmd_data, cmd_len});
    else passed++;
  endtask

  task automatic test_write;
    int c0 = cmd_cnt, e0 = err_cnt;
    cmd_ready = 1'b1;
    send_str("{a:3CD:1aAfF}");
    idle(3);
    total++;
    if (cmd_cnt - c0 !== 1) $display("FAIL write_cmd_count: got %0d, required 1", cmd_cnt - c0); else passed++;
    chk_cmd("write_fields", 1'b1, 2'd0, 12'h3CD, 20'h1AAFF, 3'd5);
    total++;
    if (err_cnt - e0 !== 0) $display("FAIL write_no_err: got %0d errors, required 0", err_cnt - e0); else passed++;
  endtask

  task automatic test_backpressure;
    int c0 = cmd_cnt, bad = 0;
    cmd_ready = 1'b0;
    send_str("{C:7:AB}");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rx_data  = "{";
        rx_valid = 1'b1;
      end
      if (cmd_valid !== 1'b1 || rx_ready !== 1'b0 || cmd_addr !== 12'h007 || cmd_data !== 20'h000AB) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL bp_hold: got %0d bad cycles, required 0", bad); else passed++;
    total++;
    if (cmd_cnt - c0 !== 0) $display("FAIL bp_no_transfer: got %0d, required 0", cmd_cnt - c0); else passed++;
    cmd_ready = 1'b1;
    send_byte("{");
    send_str("B:4:}");
    idle(3);
    total++;
    if (cmd_cnt - c0 !== 2) $display("FAIL bp_cmd_count: got %0d, required 2", cmd_cnt - c0); else passed++;
    chk_cmd("bp_second_cmd_empty_data", 1'b0, 2'd1, 12'h004, 20'h00000, 3'd0);
  endtask

  task automatic test_held_fields;
    int c0 = cmd_cnt;
    cmd_ready = 1'b0;
    send_str("{C:7:AB}");
    idle(2);
    cmd_ready = 1'b1;
    idle(3);
    total++;
    if (cmd_cnt - c0 !== 1) $display("FAIL held_cmd_count: got %0d, required 1", cmd_cnt - c0); else passed++;
    chk_cmd("held_read_fields", 1'b0, 2'd2, 12'h007, 20'h000AB, 3'd2);
  endtask

  task automatic test_errors;
    int c0 = cmd_cnt, e0 = err_cnt;
    send_str("{e:1:2}");
    idle(2);
    total++;
    if (err_cnt - e0 !== 1 || rec_code !== 3'd2) $display("FAIL err_channel: got %0d errs code %0d, required 1 code 2", err_cnt - e0, rec_code); else passed++;
    send_str("{b::5}");
    idle(2);
    total++;
    if (err_cnt - e0 !== 2 || rec_code !== 3'd4) $display("FAIL err_empty_addr: got %0d errs code %0d, required 2 code 4", err_cnt - e0, rec_code); else passed++;
    send_str("{a:123");
    total++;
    if (err !== 1'b0) $display("FAIL addr_3_digits_ok: got err %b, required 0", err); else passed++;
    send_byte("4");
    total++;
    if (err !== 1'b1 || err_code !== 3'd3) $display("FAIL err_addr_overflow: got %b code %0d, required 1 code 3", err, err_code); else passed++;
    send_str(":0}");
    send_str("{a:1:12345");
    total++;
    if (err !== 1'b0) $display("FAIL data_5_digits_ok: got err %b, required 0", err); else passed++;
    send_byte("6");
    total++;
    if (err !== 1'b1 || err_code !== 3'd3) $display("FAIL err_data_overflow: got %b code %0d, required 1 code 3", err, err_code); else passed++;
    send_str("}");
    send_str("{a:1G");
    total++;
    if (err !== 1'b1 || err_code !== 3'd1) $display("FAIL err_illegal_char: got %b code %0d, required 1 code 1", err, err_code); else passed++;
    idle(3);
    total++;
    if (cmd_cnt - c0 !== 0) $display("FAIL err_no_cmd: got %0d, required 0", cmd_cnt - c0); else passed++;
  endtask

  task automatic test_timeout;
    int n = 0, c0 = cmd_cnt;
    send_str("{a:1");
    while (err !== 1'b1 && n < T + 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n < T || n > T + 3) $display("FAIL timeout_latency: got %0d cycles, required %0d..%0d", n, T, T + 3); else passed++;
    total++;
    if (err_code !== 3'd5) $display("FAIL timeout_code: got %0d, required 5", err_code); else passed++;
    send_str("{A:3CD:ABCDE}");
    idle(3);
    total++;
    if (cmd_cnt - c0 !== 1) $display("FAIL timeout_next_count: got %0d, required 1", cmd_cnt - c0); else passed++;
    chk_cmd("timeout_next_read", 1'b0, 2'd0, 12'h3CD, 20'hABCDE, 3'd5);
  endtask

  task automatic test_restart;
    int c0 = cmd_cnt, e0 = err_cnt;
    send_str("{a:12{b:5:9}");
    idle(3);
    total++;
    if (cmd_cnt - c0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL restart_counts: got %0d cmds %0d errs, required 1 cmd 0 errs", cmd_cnt - c0, err_cnt - e0);
    else passed++;
    chk_cmd("restart_fields", 1'b1, 2'd1, 12'h005, 20'h00009, 3'd1);
  endtask

  task automatic test_reset_mid;
    int c0 = cmd_cnt, e0 = err_cnt;
    send_str("{a:1:12");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (rx_ready !== 1'b1) $display("FAIL rst_mid_rx_ready: got %b, required 1", rx_ready); else passed++;
    send_byte("}");
    idle(4);
    total++;
    if (cmd_cnt - c0 !== 0 || err_cnt - e0 !== 0)
      $display("FAIL rst_mid_silent: got %0d cmds %0d errs, required 0/0", cmd_cnt - c0, err_cnt - e0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_backpressure();
    test_held_fields();
    test_errors();
    test_timeout();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
